// File: rtl/mem_stage_pkg.sv
// Shared definitions for the pipelined memory-access stage:
// size codes, FSM states and lane/extension helpers.
package mem_stage_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {IDLE, WAIT} state_e;

  // Lane mask for up to 8 lanes; callers truncate to their width.
  function automatic logic [7:0] lane_en(
    input logic [1:0] sz,
    input logic [2:0] off
  );
    logic [7:0] m;
    unique case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [63:0] store_rep(
    input logic [1:0]  sz,
    input logic [63:0] d
  );
    logic [63:0] r;
    unique case (sz)
      SZ_B:    r = {8{d[7:0]}};
      SZ_H:    r = {4{d[15:0]}};
      SZ_W:    r = {2{d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] load_ext(
    input logic [1:0]  sz,
    input logic [2:0]  off,
    input logic        uns,
    input logic [63:0] w
  );
    logic [63:0] s;
    logic [63:0] r;
    s = w >> {off, 3'b000};
    unique case (sz)
      SZ_B:    r = {{56{~uns & s[7]}}, s[7:0]};
      SZ_H:    r = {{48{~uns & s[15]}}, s[15:0]};
      SZ_W:    r = {{32{~uns & s[31]}}, s[31:0]};
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_pipelined_ram.sv
// Byte-enabled synchronous RAM with an RD_LAT-deep read pipeline.
// The array itself has no reset.
module data_ram_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q  [2**ADDR_W];
  logic [DATA_W-1:0] pipe_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) pipe_q[0] <= mem_q[addr];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rdata = pipe_q[RD_LAT-1];

endmodule

// File: rtl/mem_stage_pipelined.sv
// Memory-access stage: alignment check, load FSM with stall,
// byte-enabled RAM access and the MEM/WB register.
module mem_stage_pipelined
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_write_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  input  logic              ex_mem_to_reg,
  input  logic              ex_reg_write,
  input  logic              flush,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic              wb_mem_to_reg,
  output logic              wb_reg_write,
  output logic              wb_mem_err
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic [1:0]        sz_q;
  logic [2:0]        off_q;
  logic              uns_q;
  logic [DATA_W-1:0] alu_q;
  logic [REG_W-1:0]  rg_q;
  logic              m2r_q;
  logic              rw_q;

  logic              aligned;
  logic              mem_op;
  logic              fault;
  logic              ld_ok;
  logic              st_ok;
  logic              accept;
  logic [2:0]        off;
  logic [NB-1:0]     ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] ld_data;

  assign off = 3'(ex_alu_result[OFF-1:0]);

  always_comb begin
    aligned = 1'b0;
    unique case (ex_mem_size)
      SZ_B: aligned = 1'b1;
      SZ_H: aligned = ~ex_alu_result[0];
      SZ_W: aligned = ex_alu_result[1:0] == 2'b00;
      SZ_D: aligned = (DATA_W == 64) && (ex_alu_result[2:0] == 3'b000);
    endcase
  end

  assign mem_op = ex_mem_read | ex_mem_write;
  assign fault  = mem_op & ((ex_mem_read & ex_mem_write) | ~aligned);
  assign ld_ok  = ex_mem_read & ~ex_mem_write & aligned;
  assign st_ok  = ex_mem_write & ~ex_mem_read & aligned;
  assign accept = (state_q == IDLE) & ex_valid & ~flush;

  // Reset gates stall so a load parked on ex_* cannot hold upstream.
  always_comb begin
    stall = 1'b0;
    if (rst) begin
      if (state_q == IDLE) stall = accept & ld_ok;
      else                 stall = cnt_q != 2'd0;
    end
  end

  assign ram_be    = NB'(lane_en(ex_mem_size, off));
  assign ram_wdata = DATA_W'(store_rep(ex_mem_size, 64'(ex_store_data)));
  assign ld_data   = DATA_W'(load_ext(sz_q, off_q, uns_q, 64'(ram_rdata)));

  data_ram_be #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk   (clk),
    .we    (accept & st_ok),
    .re    (accept & ld_ok),
    .be    (ram_be),
    .addr  (ex_alu_result[ADDR_W+OFF-1:OFF]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      sz_q          <= SZ_B;
      off_q         <= 3'd0;
      uns_q         <= 1'b0;
      alu_q         <= '0;
      rg_q          <= '0;
      m2r_q         <= 1'b0;
      rw_q          <= 1'b0;
      wb_valid      <= 1'b0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_write_reg  <= '0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_err    <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_mem_err   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept && ld_ok) begin
            state_q <= WAIT;
            cnt_q   <= 2'(RD_LAT - 1);
            sz_q    <= ex_mem_size;
            off_q   <= off;
            uns_q   <= ex_mem_unsigned;
            alu_q   <= ex_alu_result;
            rg_q    <= ex_write_reg;
            m2r_q   <= ex_mem_to_reg;
            rw_q    <= ex_reg_write;
          end else if (accept) begin
            wb_valid      <= 1'b1;
            wb_alu_result <= ex_alu_result;
            wb_read_data  <= '0;
            wb_write_reg  <= ex_write_reg;
            wb_mem_to_reg <= ex_mem_to_reg;
            wb_reg_write  <= ex_reg_write & ~fault;
            wb_mem_err    <= fault;
          end
        end
        WAIT: begin
          if (flush) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
          end else if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else begin
            state_q       <= IDLE;
            wb_valid      <= 1'b1;
            wb_alu_result <= alu_q;
            wb_read_data  <= ld_data;
            wb_write_reg  <= rg_q;
            wb_mem_to_reg <= m2r_q;
            wb_reg_write  <= rw_q;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Self-checking bench for mem_stage_pipelined (32-bit, 16 words,
// read latency 3): vector table, corner sequences, random vs model.
module tb_mem_stage_pipelined;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int LAT = 3;
  localparam int NBY = 64;

  typedef struct {
    logic        v, rd, wr, uns, m2r, rw;
    logic [1:0]  sz;
    logic [31:0] a, sd;
    logic [4:0]  rg;
  } op_t;

  typedef struct {
    op_t         op;
    logic        err;
    logic [31:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ex_valid = 1'b0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0] ex_write_reg = '0;
  logic ex_mem_read = 1'b0;
  logic ex_mem_write = 1'b0;
  logic [1:0] ex_mem_size = '0;
  logic ex_mem_unsigned = 1'b0;
  logic ex_mem_to_reg = 1'b0;
  logic ex_reg_write = 1'b0;
  logic flush = 1'b0;
  logic stall, wb_valid, wb_mem_to_reg, wb_reg_write, wb_mem_err;
  logic [31:0] wb_alu_result, wb_read_data;
  logic [4:0] wb_write_reg;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] mem_m [NBY];
  vec_t tbl[$];

  always #5 clk = ~clk;

  mem_stage_pipelined #(
    .DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT), .REG_W(5)
  ) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .flush(flush), .stall(stall),
    .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
    .wb_read_data(wb_read_data), .wb_write_reg(wb_write_reg),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_mem_err(wb_mem_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic op_t mk(input logic rd, input logic wr,
                             input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] sd);
    op_t o;
    o.v = 1'b1; o.rd = rd; o.wr = wr; o.sz = sz; o.uns = uns;
    o.a = a; o.sd = sd; o.rg = 5'(a[6:2]) ^ 5'd7;
    o.m2r = rd; o.rw = ~wr;
    return o;
  endfunction

  function automatic bit legal(input op_t o);
    int n;
    if (!o.rd && !o.wr) return 1'b1;
    if (o.rd && o.wr) return 1'b0;
    if (o.sz == 2'd3) return 1'b0;
    n = 1 << o.sz;
    return (o.a % n) == 0;
  endfunction

  function automatic logic [31:0] model_load(input op_t o);
    int idx = int'(o.a % NBY);
    int n = 1 << o.sz;
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++)
      v = v | (32'(mem_m[(idx + i) % NBY]) << (8 * i));
    if (!o.uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input op_t o);
    int idx = int'(o.a % NBY);
    int n = 1 << o.sz;
    for (int i = 0; i < n; i++)
      mem_m[(idx + i) % NBY] = 8'(o.sd >> (8 * i));
  endtask

  task automatic drive(input op_t o);
    ex_valid = o.v; ex_alu_result = o.a; ex_store_data = o.sd;
    ex_write_reg = o.rg; ex_mem_read = o.rd; ex_mem_write = o.wr;
    ex_mem_size = o.sz; ex_mem_unsigned = o.uns;
    ex_mem_to_reg = o.m2r; ex_reg_write = o.rw; flush = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the WB check.
  task automatic do_op(input op_t o, input logic xerr,
                       input logic [31:0] xd, input string nm);
    bit ld = o.v && o.rd && !xerr;
    drive(o);
    #1;
    if (ld) begin
      for (int k = 0; k < LAT; k++) begin
        chk({nm, " stall_hi"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
      end
    end
    chk({nm, " stall_lo"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    if (o.v && o.wr && !o.rd && !xerr) model_store(o);
    chk({nm, " wb_valid"}, 32'(wb_valid), 32'(o.v));
    chk({nm, " wb_err"}, 32'(wb_mem_err), 32'(o.v && xerr));
    chk({nm, " wb_rw"}, 32'(wb_reg_write), 32'(o.v && o.rw && !xerr));
    if (o.v) begin
      chk({nm, " wb_alu"}, wb_alu_result, o.a);
      chk({nm, " wb_rg"}, 32'(wb_write_reg), 32'(o.rg));
      chk({nm, " wb_m2r"}, 32'(wb_mem_to_reg), 32'(o.m2r));
    end
    if (ld) chk({nm, " wb_data"}, wb_read_data, xd);
  endtask

  task automatic add(input op_t o, input logic e, input logic [31:0] d);
    vec_t v;
    v.op = o; v.err = e; v.data = d;
    tbl.push_back(v);
  endtask

  initial begin
    op_t o;
    for (int i = 0; i < NBY; i++) mem_m[i] = 8'h00;

    add(mk(0, 1, 2, 0, 32'h10, 32'hDEADBEEF), 0, 32'h0);
    add(mk(1, 0, 2, 0, 32'h10, 0), 0, 32'hDEADBEEF);
    add(mk(1, 0, 0, 0, 32'h13, 0), 0, 32'hFFFFFFDE);
    add(mk(1, 0, 0, 1, 32'h13, 0), 0, 32'h000000DE);
    add(mk(1, 0, 1, 0, 32'h12, 0), 0, 32'hFFFFDEAD);
    add(mk(1, 0, 1, 1, 32'h12, 0), 0, 32'h0000DEAD);
    add(mk(1, 0, 2, 0, 32'h12, 0), 1, 32'h0);
    add(mk(0, 1, 1, 0, 32'h11, 32'hFFFF), 1, 32'h0);
    add(mk(1, 0, 2, 0, 32'h10, 0), 0, 32'hDEADBEEF);
    add(mk(0, 1, 2, 0, 32'h40, 32'h11111111), 0, 32'h0);
    add(mk(1, 0, 2, 0, 32'h00, 0), 0, 32'h11111111);
    add(mk(0, 0, 2, 0, 32'h1234, 0), 0, 32'h0);
    add(mk(1, 0, 3, 0, 32'h18, 0), 1, 32'h0);
    add(mk(1, 1, 2, 0, 32'h20, 0), 1, 32'h0);
    add(mk(0, 1, 2, 0, 32'h20, 0), 0, 32'h0);
    add(mk(0, 1, 0, 0, 32'h21, 32'hAB), 0, 32'h0);
    add(mk(1, 0, 2, 0, 32'h20, 0), 0, 32'h0000AB00);
    add(mk(0, 1, 0, 0, 32'h23, 32'h80), 0, 32'h0);
    add(mk(1, 0, 0, 0, 32'h23, 0), 0, 32'hFFFFFF80);
    add(mk(1, 0, 1, 0, 32'h22, 0), 0, 32'hFFFF8000);
    add(mk(0, 1, 2, 0, 32'h30, 32'hCAFEF00D), 0, 32'h0);

    // Reset values while rst is held low
    #3;
    chk("rst stall", 32'(stall), 0);
    chk("rst wb_valid", 32'(wb_valid), 0);
    chk("rst wb_alu", wb_alu_result, 0);
    chk("rst wb_data", wb_read_data, 0);
    chk("rst wb_rw", 32'(wb_reg_write), 0);
    chk("rst wb_err", 32'(wb_mem_err), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < 16; w++)
      do_op(mk(0, 1, 2, 0, 32'(w * 4), 0), 0, 0, "fill");

    foreach (tbl[i])
      do_op(tbl[i].op, tbl[i].err, tbl[i].data, $sformatf("vec%0d", i));

    // Reset asserted while a load waits
    do_op(mk(0, 0, 0, 0, 32'h5A5A, 0), 0, 0, "pre_rst");
    drive(mk(1, 0, 2, 0, 32'h10, 0));
    #1 chk("rw issue stall", 32'(stall), 1);
    @(posedge clk); #1;
    chk("rw wait stall", 32'(stall), 1);
    rst = 1'b0;
    #1;
    chk("rw stall", 32'(stall), 0);
    chk("rw wb_valid", 32'(wb_valid), 0);
    chk("rw wb_alu", wb_alu_result, 0);
    chk("rw wb_rg", 32'(wb_write_reg), 0);
    chk("rw wb_m2r", 32'(wb_mem_to_reg), 0);
    chk("rw wb_rw", 32'(wb_reg_write), 0);
    chk("rw wb_err", 32'(wb_mem_err), 0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rw after wb_valid", 32'(wb_valid), 0);
    do_op(mk(0, 0, 0, 0, 32'h77, 0), 0, 0, "post_rst_add");
    do_op(mk(1, 0, 2, 0, 32'h10, 0), 0, 32'hDEADBEEF, "post_rst_lw");

    // Flush during WAIT
    drive(mk(1, 0, 2, 0, 32'h10, 0));
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl wb_valid", 32'(wb_valid), 0);
    chk("fl wb_rw", 32'(wb_reg_write), 0);
    do_op(mk(0, 0, 0, 0, 32'h99, 0), 0, 0, "fl_add");

    // Flushed store must not write
    drive(mk(0, 1, 2, 0, 32'h30, 32'h55555555));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fls wb_valid", 32'(wb_valid), 0);
    do_op(mk(1, 0, 2, 0, 32'h30, 0), 0, 32'hCAFEF00D, "fls_lw");

    // Random traffic against the byte-array model
    for (int i = 0; i < 200; i++) begin
      int r = $urandom_range(0, 9);
      o = mk(r <= 3 || r == 9, (r >= 4 && r <= 6) || r == 9,
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 127)), $urandom);
      o.v = $urandom_range(0, 9) != 0;
      o.rw = 1'($urandom_range(0, 1));
      if (o.sz != 2'd3 && $urandom_range(0, 3) != 0)
        o.a = o.a & ~((32'd1 << o.sz) - 1);
      do_op(o, o.v && !legal(o), (o.rd && legal(o)) ? model_load(o) : 0,
            $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_pipelined.md
# mem_stage_pipelined

Parametrised memory-access stage that replaces the single-cycle data-memory/MEM-WB pair. It sits between EX/MEM and WB. It contains a byte-enabled data RAM with configurable read latency. It handles byte, half, word and (64-bit builds) dword loads and stores with sign/zero extension, and stalls upstream while a load is outstanding. It flags misaligned or illegal accesses and registers all results into a valid-qualified MEM/WB register with flush.

## Interface
- DATA_W, 32: data path width; legal values 32 or 64.
- ADDR_W, 10: word-index width; RAM depth = 2^ADDR_W words.
- RD_LAT, 1: RAM read latency in cycles; legal range 1..4.
- REG_W, 5: destination register index width.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  EX/MEM holds a live instruction.
- ex_alu_result  in  DATA_W  byte address, or ALU result.
- ex_store_data  in  DATA_W  store data, LSB-aligned.
- ex_write_reg  in  REG_W  destination register.
- ex_mem_read / ex_mem_write  in  1 each  load / store request.
- ex_mem_size  in  2  0 byte, 1 half, 2 word, 3 dword (DATA_W=64 only).
- ex_mem_unsigned  in  1  zero-extend loads.
- ex_mem_to_reg, ex_reg_write  in  1 each  WB controls.
- flush  in  1  kill the instruction in this stage.
- stall  out  1  upstream must hold EX/MEM this cycle.
- wb_valid  out  1  MEM/WB register holds a live instruction.
- wb_alu_result  out  DATA_W  registered ALU result.
- wb_read_data  out  DATA_W  registered extended load data.
- wb_write_reg  out  REG_W  registered destination.
- wb_mem_to_reg, wb_reg_write  out  1 each  registered controls.
- wb_mem_err  out  1  registered error flag, one cycle per faulting instruction.

## Operation
- Byte offset is OFF = log2(DATA_W/8) bits. Word index = ex_alu_result[ADDR_W+OFF-1:OFF]. Higher address bits are ignored, so the address wraps modulo the RAM depth.
- Alignment: half needs addr[0]=0. Word needs addr[1:0]=0. Dword needs addr[2:0]=0. Size 3 with DATA_W=32 is illegal. mem_read and mem_write both high is illegal.
- Fault (misaligned or illegal):
  - RAM is untouched and there is no stall.
  - The instruction is retired with wb_reg_write=0 and wb_mem_err=1.
- Store: byte-lane enables are derived from size and offset. Data is replicated into the selected lanes. Written at the edge ending the accept cycle. No stall; WB entry next cycle with wb_reg_write as supplied.
- Load: the lane is selected by offset and size, then sign- or zero-extended to DATA_W.
- Non-memory op: passes through in 1 cycle.
- FSM states IDLE and WAIT, with counter cnt (2 bits):
  - IDLE, ex_valid && legal load && !flush: issue RAM read, stall=1, go to WAIT with cnt=RD_LAT-1. MEM/WB loads a bubble.
  - WAIT, cnt≠0: stall=1, cnt decrements, bubble.
  - WAIT, cnt=0: stall=0. Load result and held controls are captured into MEM/WB. Go to IDLE.
  - flush in any state: go to IDLE, and the next wb_valid=0. An in-flight read is discarded. The RAM is never written by a flushed store.
- The bubble case forces wb_valid=0, wb_reg_write=0, wb_mem_err=0; other wb fields are don't-care.
- stall is combinational from state, cnt and the ex_* inputs. Upstream holds ex_* stable while stall=1.

## Timing
- Reset (rst low, asynchronous): state=IDLE, cnt=0, every wb_* output = 0, stall=0. RAM contents are not cleared.
- Reset released mid-load: no response for the aborted load. Upstream must re-issue it.
- Latency:
  - Non-load, store or fault accepted in cycle T: wb_valid=1 in T+1.
  - Legal load accepted in cycle T: stall=1 for cycles T..T+RD_LAT-1; wb_valid=1 with data in T+RD_LAT+1.
- Store followed by a load to the same address: the load returns the new data (write at edge T, read issued T+1 or later).
- ex_valid=0 produces a bubble; the FSM stays in IDLE.

## Structure
- Package mem_stage_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - state enum {IDLE, WAIT};
  - function for lane enable by size and offset;
  - function for load extract/extend.
- Sub-module data_ram_be(DATA_W, ADDR_W, RD_LAT): byte-enabled synchronous RAM with an RD_LAT-deep read-data pipeline and no reset on the array.
- The top level holds the FSM, alignment check and MEM/WB register.

## Test plan
- Reset: drive rst low mid-WAIT -> all wb_*=0 and stall=0 immediately; after release the state is IDLE.
- RD_LAT=3, SW 0xDEADBEEF @0x10, then LW @0x10 -> stall high exactly 3 cycles; wb_valid with wb_read_data=0xDEADBEEF on the 4th cycle after accept.
- LB @0x13 -> 0xFFFFFFDE, LBU -> 0x000000DE, LH @0x12 -> 0xFFFFDEAD, LHU -> 0x0000DEAD.
- LW @0x12 and SH @0x11 -> no stall, wb_mem_err=1, wb_reg_write=0; RAM word @0x10 unchanged.
- Address wrap, ADDR_W=4: SW 0x11111111 @0x40 -> LW @0x00 returns 0x11111111.
- flush during WAIT -> next wb_valid=0; state is IDLE; the following ADD passes with wb_valid=1 next cycle.
